// File: rtl/ignition_sequencer.sv
// ignition_sequencer: angle-scheduled multi-cylinder coil driver.
// Each channel latches advance/dwell at a point half an engine cycle away
// from its TDC, then charges its coil from the dwell-start angle (DS) to
// the spark angle (SP). The falling edge of coil[i] is the spark.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   on                  engine enable; low forces every channel OFF
//   allow_ignition      global spark permit, sampled at dwell start
//   sync_ok             decoder sync; low aborts armed/charging channels
//   crank_tick          one-clock strobe qualifying crank_angle
//   crank_angle         absolute angle 0..ANGLE_MAX-1
//   advance, dwell_angle requested timing in angle ticks
//   cal_ignition        one-clock recompute request per cylinder
//   coil                coil charge outputs
//   overdwell           sticky per-channel forced-release flags
//   clamp_flag          sticky: a timing request was clamped
//   sync_abort          pulse: sync lost while a coil was charged
`ifndef CFG_CYLINDERS
`define CFG_CYLINDERS 4
`endif

module ignition_sequencer #(
  parameter int unsigned CYLINDERS      = `CFG_CYLINDERS,
  parameter int unsigned ANGLE_MAX      = 720,
  parameter int unsigned ANGLE_W        = 10,
  parameter int unsigned MAX_DWELL_CLKS = 500000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 on,
  input  logic                 allow_ignition,
  input  logic                 sync_ok,
  input  logic                 crank_tick,
  input  logic [ANGLE_W-1:0]   crank_angle,
  input  logic [ANGLE_W-1:0]   advance,
  input  logic [ANGLE_W-1:0]   dwell_angle,
  output logic [CYLINDERS-1:0] cal_ignition,
  output logic [CYLINDERS-1:0] coil,
  output logic [CYLINDERS-1:0] overdwell,
  output logic                 clamp_flag,
  output logic                 sync_abort
);

  typedef enum logic [1:0] {OFF, ARMED, DWELL, FIRED} state_e;
  typedef logic [ANGLE_W-1:0] angle_t;
  typedef logic [ANGLE_W:0]   wide_t;

  localparam int unsigned HALF    = ANGLE_MAX / 2;
  localparam int unsigned SPACING = ANGLE_MAX / CYLINDERS;
  localparam wide_t       AMAX_W  = wide_t'(ANGLE_MAX);
  localparam wide_t       HALF_W  = wide_t'(HALF);

  wide_t                req_sum;
  angle_t               adv_c, dwl_c;
  logic                 clamp_c;
  logic [CYLINDERS-1:0] latch;
  logic                 clamp_flag_q, clamp_flag_d;
  logic                 sync_abort_q, sync_abort_d;

  // Spark plus dwell must fit inside half a cycle so the window never
  // reaches back past the channel's own latch point.
  always_comb begin
    req_sum = {1'b0, advance} + {1'b0, dwell_angle};
    adv_c   = advance;
    dwl_c   = dwell_angle;
    clamp_c = 1'b0;
    if (req_sum >= HALF_W) begin
      clamp_c = 1'b1;
      if ({1'b0, advance} >= HALF_W) begin
        adv_c = angle_t'(HALF - 1);
        dwl_c = '0;
      end else begin
        dwl_c = angle_t'(HALF_W - wide_t'(1) - {1'b0, advance});
      end
    end
  end

  always_comb begin
    clamp_flag_d = clamp_flag_q;
    if (!on)                        clamp_flag_d = 1'b0;
    else if ((|latch) && clamp_c)   clamp_flag_d = 1'b1;
    sync_abort_d = !sync_ok && (|coil);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clamp_flag_q <= 1'b0;
      sync_abort_q <= 1'b0;
    end else begin
      clamp_flag_q <= clamp_flag_d;
      sync_abort_q <= sync_abort_d;
    end
  end

  assign clamp_flag = clamp_flag_q;
  assign sync_abort = sync_abort_q;

  for (genvar i = 0; i < CYLINDERS; i++) begin : g_ch
    localparam int unsigned      TDC      = i * SPACING;
    localparam angle_t           LP       = angle_t'((TDC + HALF) % ANGLE_MAX);
    localparam wide_t            TDC_W    = wide_t'(TDC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_DWELL_CLKS - 1);

    state_e           st_q, st_d;
    angle_t           sp_sh_q, sp_sh_d, ds_sh_q, ds_sh_d;
    angle_t           sp_q, sp_d, ds_q, ds_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovd_q, ovd_d, cal_q, cal_d;
    wide_t            sp_raw, ds_raw;
    angle_t           sp_c, ds_c;
    logic             match_ds, match_sp, coil_c;

    assign latch[i] = on && crank_tick && (crank_angle == LP);
    assign match_ds = crank_tick && (crank_angle == ds_q);
    assign match_sp = crank_tick && (crank_angle == sp_q);

    // Both subtractions add ANGLE_MAX first so intermediates stay positive.
    always_comb begin
      sp_raw = TDC_W + AMAX_W - {1'b0, adv_c};
      sp_c   = (sp_raw >= AMAX_W) ? angle_t'(sp_raw - AMAX_W) : angle_t'(sp_raw);
      ds_raw = {1'b0, sp_c} + AMAX_W - {1'b0, dwl_c};
      ds_c   = (ds_raw >= AMAX_W) ? angle_t'(ds_raw - AMAX_W) : angle_t'(ds_raw);
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        st_q    <= OFF;
        sp_sh_q <= '0;
        ds_sh_q <= '0;
        sp_q    <= '0;
        ds_q    <= '0;
        cnt_q   <= '0;
        ovd_q   <= 1'b0;
        cal_q   <= 1'b0;
      end else begin
        st_q    <= st_d;
        sp_sh_q <= sp_sh_d;
        ds_sh_q <= ds_sh_d;
        sp_q    <= sp_d;
        ds_q    <= ds_d;
        cnt_q   <= cnt_d;
        ovd_q   <= ovd_d;
        cal_q   <= cal_d;
      end
    end

    // Shadow targets follow every latch event; the FSM's working targets
    // are copied from the shadow only on ARMED entry.
    always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      ovd_d   = ovd_q;
      cal_d   = latch[i];
      sp_sh_d = latch[i] ? sp_c : sp_sh_q;
      ds_sh_d = latch[i] ? ds_c : ds_sh_q;
      sp_d    = sp_q;
      ds_d    = ds_q;
      if (!on) begin
        st_d  = OFF;
        ovd_d = 1'b0;
      end else begin
        case (st_q)
          OFF: begin
            if (latch[i] && sync_ok) begin
              st_d = ARMED;
              sp_d = sp_sh_d;
              ds_d = ds_sh_d;
            end
          end
          ARMED: begin
            if (!sync_ok) begin
              st_d = OFF;
            end else if (match_ds && allow_ignition) begin
              cnt_d = '0;
              st_d  = (ds_q == sp_q) ? FIRED : DWELL;
            end
          end
          DWELL: begin
            if (!sync_ok) begin
              st_d = OFF;
            end else if (match_sp) begin
              st_d = FIRED;
            end else if (cnt_q == CNT_LAST) begin
              st_d  = FIRED;
              ovd_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          FIRED:   st_d = OFF;
          default: st_d = OFF;
        endcase
      end
    end

    always_comb begin
      coil_c = (st_q == DWELL);
    end

    assign coil[i]         = coil_c;
    assign cal_ignition[i] = cal_q;
    assign overdwell[i]    = ovd_q;
  end

endmodule

// File: doc/ignition_sequencer.md
Name: ignition_sequencer

Overview:
- Multi-cylinder, angle-scheduled coil driver.
- Consumes the absolute 720-degree crank angle from the crank/cam decoder.
- Latches per-cylinder advance and dwell (both in angle ticks) once per engine cycle.
- Drives one coil output per cylinder: high during dwell, falling edge is the spark.
- Adds over-dwell protection, sync-loss abort and per-cylinder calculation requests.
- Sits between the ignition timing calculator and the coil driver pins.

Parameters:
CYLINDERS, `CFG_CYLINDERS, number of coil channels (1..8)
ANGLE_MAX, 720, crank ticks per engine cycle; cylinder i TDC = i*(ANGLE_MAX/CYLINDERS)
ANGLE_W, 10, width of angle buses; ANGLE_MAX <= 2**ANGLE_W
MAX_DWELL_CLKS, 500000, clock cycles a coil may stay charged before forced release
CNT_W, 20, width of the over-dwell counter; MAX_DWELL_CLKS < 2**CNT_W

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
on  in  1  engine enable; low forces all channels to OFF synchronously
allow_ignition  in  1  global spark permit (kill switch, rev limiter)
sync_ok  in  1  decoder has valid crank/cam sync
crank_tick  in  1  one-clock strobe; crank_angle is valid and has just advanced by 1
crank_angle  in  ANGLE_W  absolute angle 0..ANGLE_MAX-1
advance  in  ANGLE_W  spark advance before TDC, ticks
dwell_angle  in  ANGLE_W  dwell length, ticks
cal_ignition  out  CYLINDERS  one-clock request to recompute timing for cylinder i
coil  out  CYLINDERS  coil charge outputs
overdwell  out  CYLINDERS  sticky: channel i was force-released; cleared by reset or on low
clamp_flag  out  1  sticky: an advance+dwell request was clamped
sync_abort  out  1  one-clock pulse when sync_ok falls while any coil is charged

Behaviour:
- Reset state: all outputs 0, every channel OFF, shadow registers 0, counters 0.
- Latch point of channel i: LP_i = (TDC_i + ANGLE_MAX/2) mod ANGLE_MAX.
- At crank_tick with crank_angle == LP_i:
  - Sample advance and dwell_angle into the shadow registers of channel i.
  - Pulse cal_ignition[i] on the next clock.
- Clamp: if advance + dwell_angle >= ANGLE_MAX/2:
  - Use dwell = ANGLE_MAX/2 - 1 - advance, floored at 0.
  - If advance >= ANGLE_MAX/2, use advance = ANGLE_MAX/2 - 1 and dwell = 0.
  - Set clamp_flag.
- Registered targets, all arithmetic mod ANGLE_MAX:
  - SP_i = TDC_i - adv.
  - DS_i = SP_i - dwell.
  - Wrap is handled by adding ANGLE_MAX before subtraction. No negative intermediate values.
- Per-channel FSM, states OFF, ARMED, DWELL, FIRED:
  - OFF -> ARMED: at the latch event, if on && sync_ok.
  - ARMED -> DWELL: at crank_tick with crank_angle == DS_i, if allow_ignition. Otherwise stay ARMED.
  - DWELL -> FIRED: at crank_tick with crank_angle == SP_i. coil[i] falls on the clock after the matching tick.
  - FIRED -> OFF: immediately on the next clock.
- Zero-dwell case: DS_i == SP_i, so no DWELL occurs. The channel goes ARMED -> FIRED without raising coil.
- Latency: coil[i] rises exactly 1 clock after the crank_tick matching DS_i. It falls exactly 1 clock after the tick matching SP_i.
- Over-dwell:
  - The counter resets on DWELL entry and increments every clock in DWELL.
  - On reaching MAX_DWELL_CLKS: coil drops, overdwell[i] sets, channel goes to FIRED.
- allow_ignition falling during DWELL does not abort the charge. The spark still occurs at SP_i.
- sync_ok low: every ARMED or DWELL channel goes to OFF and coil drops the next clock. sync_abort pulses if any coil was high.
- on low: all channels to OFF, coil=0, overdwell=0. clamp_flag also clears. Shadow registers are held.
- A latch event arriving while the channel is not OFF: shadow registers and cal_ignition still update. The FSM is unaffected; new targets apply from the next ARMED entry.
- Simultaneous events on different channels are independent. Overlapping dwell windows of adjacent cylinders are legal.
- crank_angle values >= ANGLE_MAX never match any target.

Test Plan:
- CYLINDERS=4, advance=10, dwell=30, steady ticks:
  - Cylinder 1 (TDC 180) coil rises 1 clk after angle 140, falls 1 clk after angle 170.
  - cal_ignition[1] pulses at angle 540.
- Cylinder 0, advance=15, dwell=40 -> SP=705, DS=665 (wrap). coil[0] high from 665 to 705.
- advance=300, dwell=100 -> dwell clamped to 59, clamp_flag=1, coil high 59 ticks.
- Stop ticks during DWELL with MAX_DWELL_CLKS=1000 -> coil drops at clk 1000, overdwell[i]=1, no second rise this cycle.
- Drop sync_ok mid-dwell -> coil=0 next clk, sync_abort single pulse.
  - Drop on instead -> all state cleared.
  - Assert reset_n low asynchronously mid-dwell -> coil=0 immediately.
- allow_ignition=0 at DS -> no coil rise that cycle.
  - Raise allow_ignition during DWELL of another channel -> that channel still fires at SP.
